// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game-level controller slice.
//   - state_t   : game state encoding (IDLE / PLAY / OVER)
//   - DEF_GRID_W, DEF_GRID_H : default playfield size in cells
//   - LFSR_TAPS : tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   - lfsr_feedback : XOR of the tapped bits, shifted in at bit 0
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int DEF_GRID_W = 32;
  localparam int DEF_GRID_H = 24;

  // Taps 16,14,13,11 map to register bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: four-digit BCD up-counter that saturates at 9999.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset, clears the count
//   inc  - add one on this edge (ignored at 9999)
//   clr  - synchronous clear, wins over inc
//   q    - BCD count, digit 3 in q[15:12]
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] q
);

  logic [15:0] next_q;
  logic        carry;

  // Ripple a +1 through the digits: a 9 rolls to 0 and passes the carry on,
  // any other digit absorbs it.
  always_comb begin
    next_q = q;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (q[i*4 +: 4] == 4'd9) begin
          next_q[i*4 +: 4] = 4'd0;
        end else begin
          next_q[i*4 +: 4] = q[i*4 +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  // Holding at 9999 keeps the display from wrapping to 0000 on a long game.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != 16'h9999)) begin
      q <= next_q;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game-level controller downstream of the collision/eat checker.
// Debounces eat flags to one per frame, runs the IDLE/PLAY/OVER FSM, keeps
// score (BCD) and snake length, and relocates the cherry using an LFSR.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   start_btn         - start/restart button level (rising edge acts)
//   frame_tick        - one-cycle pulse per movement step
//   snake_eat_cherry  - checker eat flag (may repeat within a frame)
//   bump              - checker collision flag
//   state             - 0=IDLE 1=PLAY 2=OVER
//   move_en           - registered frame_tick, only in PLAY
//   grow              - one-cycle pulse per accepted eat
//   snake_len, score  - length and 4-digit BCD score
//   cherry_x/y/valid  - cherry cell; valid low while relocating
//   game_over         - high while in OVER
module game_ctrl
  import game_pkg::*;
#(
  parameter int          GRID_W    = DEF_GRID_W,
  parameter int          GRID_H    = DEF_GRID_H,
  parameter int          X_W       = 5,
  parameter int          Y_W       = 5,
  parameter int          INIT_LEN  = 3,
  parameter int          MAX_LEN   = 64,
  parameter int          LEN_W     = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_btn,
  input  logic             frame_tick,
  input  logic             snake_eat_cherry,
  input  logic             bump,
  output logic [1:0]       state,
  output logic             move_en,
  output logic             grow,
  output logic [LEN_W-1:0] snake_len,
  output logic [15:0]      score,
  output logic [X_W-1:0]   cherry_x,
  output logic [Y_W-1:0]   cherry_y,
  output logic             cherry_valid,
  output logic             game_over
);

  localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 2);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 2);
  localparam logic [X_W-1:0]   X_MID    = X_W'(GRID_W / 2);
  localparam logic [Y_W-1:0]   Y_MID    = Y_W'(GRID_H / 2);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  state_t         state_q;
  logic [15:0]    lfsr;
  logic           start_q;
  logic           eat_seen;
  logic           start_rise;
  logic           play_start;
  logic           accept;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           cand_legal;

  assign state      = state_q;
  assign start_rise = start_btn & ~start_q;
  assign play_start = (state_q == ST_IDLE) & start_rise;

  // An eat counts once per frame, only against a visible cherry, and never
  // when the same cycle also reports a collision.
  assign accept = (state_q == ST_PLAY) & snake_eat_cherry & ~eat_seen &
                  ~bump & cherry_valid;

  // Candidate cell comes straight from the LFSR; walls are rejected.
  assign cand_x     = lfsr[X_W-1:0];
  assign cand_y     = lfsr[8 +: Y_W];
  assign cand_legal = (cand_x != '0) && (cand_x <= X_MAX) &&
                      (cand_y != '0) && (cand_y <= Y_MAX);

  // Free-running LFSR and button edge register, active in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr    <= LFSR_SEED;
      start_q <= 1'b0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_feedback(lfsr)};
      start_q <= start_btn;
    end
  end

  // Game FSM with registered outputs, eat latch and length counter.
  // A collision leaves PLAY without producing a final move step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      move_en   <= 1'b0;
      grow      <= 1'b0;
      game_over <= 1'b0;
      snake_len <= LEN_INIT;
      eat_seen  <= 1'b0;
    end else begin
      move_en <= 1'b0;
      grow    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          game_over <= 1'b0;
          if (start_rise) begin
            state_q   <= ST_PLAY;
            snake_len <= LEN_INIT;
            eat_seen  <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (bump) begin
            state_q   <= ST_OVER;
            game_over <= 1'b1;
          end else begin
            move_en <= frame_tick;
          end
          if (accept) begin
            eat_seen <= 1'b1;
            grow     <= 1'b1;
            if (snake_len < LEN_MAX) begin
              snake_len <= snake_len + LEN_W'(1);
            end
          end else if (frame_tick) begin
            eat_seen <= 1'b0;
          end
        end
        ST_OVER: begin
          game_over <= 1'b1;
          if (start_rise) begin
            state_q   <= ST_IDLE;
            game_over <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          game_over <= 1'b0;
        end
      endcase
    end
  end

  // Cherry relocation: hide the cherry on game start or an accepted eat,
  // then retry one LFSR candidate per cycle until a non-wall cell appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cherry_x     <= X_MID;
      cherry_y     <= Y_MID;
      cherry_valid <= 1'b1;
    end else if (play_start || accept) begin
      cherry_valid <= 1'b0;
    end else if (!cherry_valid && cand_legal) begin
      cherry_x     <= cand_x;
      cherry_y     <= cand_y;
      cherry_valid <= 1'b1;
    end
  end

  bcd_counter4 u_score (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .clr (play_start),
    .q   (score)
  );

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Game-level controller directly downstream of the collision/eat checker.
- Consumes the checker's per-pixel `snake_eat_cherry` and `bump` flags and debounces them to at most one event per movement frame.
- Runs the IDLE/PLAY/OVER game state machine.
- Maintains the BCD score and the snake length, and relocates the cherry via a free-running LFSR. Outputs feed the snake mover, the renderer and the score display.

Parameters:
- GRID_W, 32, playfield width in cells; column 0 and column GRID_W-1 are walls.
- GRID_H, 24, playfield height in cells; row 0 and row GRID_H-1 are walls.
- X_W, 5, cherry x width; 2^X_W >= GRID_W.
- Y_W, 5, cherry y width; 2^Y_W >= GRID_H.
- INIT_LEN, 3, snake length at game start.
- MAX_LEN, 64, length saturation value.
- LEN_W, 7, snake_len width; holds MAX_LEN.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- start_btn  in  1  synchronous start/restart button, level.
- frame_tick  in  1  one-cycle pulse per snake movement step.
- snake_eat_cherry  in  1  checker eat flag; may pulse several times per frame.
- bump  in  1  checker collision flag (wall or body).
- state  out  2  0=IDLE, 1=PLAY, 2=OVER.
- move_en  out  1  frame_tick gated to PLAY.
- grow  out  1  one-cycle pulse per accepted eat.
- snake_len  out  LEN_W  current length.
- score  out  16  4-digit BCD, digit 3 most significant.
- cherry_x  out  X_W  cherry cell column.
- cherry_y  out  Y_W  cherry cell row.
- cherry_valid  out  1  0 while relocating; the renderer hides the cherry.
- game_over  out  1  level, high in OVER.

Behaviour:
- **Reset (rst=0, async):**
  - state=IDLE, score=0, snake_len=INIT_LEN.
  - grow=0, move_en=0, game_over=0.
  - cherry_x=GRID_W/2, cherry_y=GRID_H/2, cherry_valid=1.
  - lfsr=LFSR_SEED; eat_seen=0, start_q=0.
  - Release is usable on the first clk edge.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in all states, never 0.
- **Start detection:** start_q registers start_btn; start_rise = start_btn & ~start_q.
- **IDLE:**
  - On start_rise → PLAY.
  - Same edge: score=0, snake_len=INIT_LEN, eat_seen=0; relocation begins (cherry_valid=0).
- **PLAY:**
  - move_en = frame_tick (registered, 1-cycle latency).
  - bump=1 → OVER on the next edge.
  - bump has priority: if snake_eat_cherry=1 in the same cycle, the eat is discarded.
- **OVER:**
  - game_over=1, move_en=0; score and length are frozen.
  - start_rise → IDLE. A second start_rise is then needed to play again.
- **Eat acceptance (PLAY only):**
  - accept = snake_eat_cherry & ~eat_seen & ~bump & cherry_valid.
  - On accept: eat_seen←1. Next edge: grow=1 for one cycle, score+1 (BCD), snake_len+1, relocation begins.
  - eat_seen clears on frame_tick. If accept and frame_tick coincide, eat_seen ends the cycle at 1 (the set wins).
  - Result: at most one accepted eat per frame, regardless of how many pulses the checker emits.
- **BCD increment:**
  - Each digit wraps 9→0 with carry.
  - 9999 saturates: stays 9999, and grow still pulses.
- **Length:** saturates at MAX_LEN; grow still pulses at saturation.
- **Relocation:**
  - While cherry_valid=0, each cycle take cx=lfsr[X_W-1:0], cy=lfsr[8+Y_W-1:8].
  - The candidate is legal if 1<=cx<=GRID_W-2 and 1<=cy<=GRID_H-2. If legal: cherry_x/cherry_y←cx/cy and cherry_valid←1. If not, retry next cycle.
  - No overlap check with the body: the checker handles this, and the next frame re-eats.
- **Reset mid-operation:** everything returns to reset values immediately. A relocation in progress is aborted.
- **state encoding 3:** unreachable; recovers to IDLE.

Decomposition:
- Shared package `game_pkg`:
  - state enum (ST_IDLE=2'd0, ST_PLAY=2'd1, ST_OVER=2'd2);
  - GRID_W, GRID_H defaults;
  - the LFSR tap constant.
- One sub-module, `bcd_counter4`:
  - ports: clk, rst, inc, clr, q[15:0];
  - 4-digit BCD increment with saturation at 9999.
- FSM, eat latch, length counter, LFSR and relocation stay in `game_ctrl`.

Test Plan:
- **Reset and start:** rst=0 for 3 cycles, then start_btn high → state 0→1 one cycle after the rising edge; score=16'h0000, snake_len=3; cherry_valid returns to 1 within 64 cycles with cherry_x in 1..30 and cherry_y in 1..22.
- **Multi-pulse eat:** in PLAY, snake_eat_cherry toggles 1,0,1,0,1 within one frame → exactly one grow pulse; score=16'h0001, snake_len=4. After frame_tick, a new eat gives score=16'h0002.
- **Eat and bump in the same cycle:** → no grow, score unchanged, state=2 next cycle, game_over=1, move_en stays 0 on subsequent frame_ticks.
- **BCD carry and saturation:** preload via 99 accepted eats → score=16'h0099; one more → 16'h0100. Drive 9999 eats → score stays 16'h9999, snake_len saturates at 64.
- **Restart path:** in OVER, start rise → IDLE (score held); second start rise → PLAY with score=0 and snake_len=3.
- **Async reset mid-relocation:** assert rst while cherry_valid=0, between clk edges → outputs take reset values immediately (cherry 16,12, valid=1, state=0).
